// File: rtl/mul_8x8_seq_pkg.sv
// Shared definitions for the sequential 8x8 shift-add multiplier.
package mul_8x8_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam logic [3:0] ITER_LAST = 4'd7;

endpackage

// File: rtl/mul_8x8_seq_if.sv
// Request/response bundle between a multiplier client (master) and the multiplier (slave).
interface mul_8x8_seq_if;

  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (output start, output a, output b, input busy, input done, input product);
  modport slave  (input start, input a, input b, output busy, output done, output product);

endinterface

// File: rtl/mul_8x8_seq_adder_8.sv
// 8-bit ripple adder with carry in/out, used for the partial-product accumulate.
module adder_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'h00, cin_i};

endmodule

// File: rtl/mul_8x8_seq.sv
// Sequential unsigned 8x8 shift-add multiplier: one multiplier bit per clock,
// one-cycle done pulse, 16-bit product held until the next completion.
module mul_8x8_seq
  import mul_8x8_seq_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_8x8_seq_if.slave bus_io
);

  mul_state_e  state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  mlr_q, mlr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  addend_s;
  logic [7:0]  sum_s;
  logic        cout_s;
  logic        zero_hit_s;

  assign addend_s   = mlr_q[0] ? mcand_q : 8'h00;
  assign zero_hit_s = ZERO_SKIP && ((bus_io.a == 8'h00) || (bus_io.b == 8'h00));

  adder_8 u_adder (
    .a_i    (acc_q),
    .b_i    (addend_s),
    .cin_i  (1'b0),
    .sum_o  (sum_s),
    .cout_o (cout_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.start) begin
          state_d = zero_hit_s ? ST_DONE : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_q == ITER_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode, taken from the next state so busy/done come straight from flops
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      ST_CALC: begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath next-state: operand capture and one shift-add iteration per CALC cycle
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mlr_d     = mlr_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.start) begin
          mcand_d = bus_io.a;
          mlr_d   = bus_io.b;
          acc_d   = 8'h00;
          cnt_d   = 4'd0;
          if (zero_hit_s) begin
            product_d = 16'h0000;
          end else begin
            product_d = product_q;
          end
        end else begin
          mcand_d = mcand_q;
        end
      end
      ST_CALC: begin
        // Carry out becomes the new MSB, so the 9-bit partial sum is never truncated
        {acc_d, mlr_d} = {cout_s, sum_s, mlr_q[7:1]};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == ITER_LAST) begin
          product_d = {cout_s, sum_s, mlr_q[7:1]};
        end else begin
          product_d = product_q;
        end
      end
      ST_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= 8'h00;
      acc_q     <= 8'h00;
      mlr_q     <= 8'h00;
      cnt_q     <= 4'd0;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mlr_q     <= mlr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus_io.busy    = busy_q;
  assign bus_io.done    = done_q;
  assign bus_io.product = product_q;

endmodule

// File: tb/tb_mul_8x8_seq.sv
// Directed bench for mul_8x8_seq: one zero-skipping instance plus a non-skipping
// twin that shares its inputs, used for the zero-operand comparison.
module tb_mul_8x8_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [15:0] last_p;

  mul_8x8_seq_if if_zs ();
  mul_8x8_seq_if if_nz ();

  assign if_nz.start = if_zs.start;
  assign if_nz.a     = if_zs.a;
  assign if_nz.b     = if_zs.b;

  mul_8x8_seq #(.ZERO_SKIP(1'b1)) u_dut_zs (.clk(clk), .rst_n(rst_n), .bus_io(if_zs.slave));
  mul_8x8_seq #(.ZERO_SKIP(1'b0)) u_dut_nz (.clk(clk), .rst_n(rst_n), .bus_io(if_nz.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single accepted operation on the zero-skipping instance; starts and ends at posedge+1.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                        input int exp_lat, input string tag);
    int lat;
    int busy_n;
    if_zs.a = a;
    if_zs.b = b;
    if_zs.start = 1'b1;
    tick();
    if_zs.start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!if_zs.done && lat < 30) begin
      if (if_zs.busy) busy_n++;
      if (lat == 4) chk({tag, "_hold"}, 32'(if_zs.product), 32'(last_p));
      tick();
      lat++;
    end
    if (if_zs.busy) busy_n++;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_n), 32'(exp_lat));
    chk({tag, "_prod"}, 32'(if_zs.product), 32'(exp_p));
    last_p = exp_p;
    tick();
    chk({tag, "_done_clr"}, 32'(if_zs.done), 32'd0);
    chk({tag, "_idle"}, 32'(if_zs.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int lat_zs;
    int lat_nz;
    int edges;
    int idx;
    int exp_iv;
    logic [15:0] p_zs;
    logic [15:0] p_nz;
    logic [15:0] exp_p;
    logic [7:0] pa[$];
    logic [7:0] pb[$];

    n_cmp = 0;
    n_err = 0;
    last_p = 16'h0000;
    rst_n = 1'b0;
    if_zs.start = 1'b0;
    if_zs.a = 8'h00;
    if_zs.b = 8'h00;

    #1;
    chk("rst_busy", 32'(if_zs.busy), 32'd0);
    chk("rst_done", 32'(if_zs.done), 32'd0);
    chk("rst_prod", 32'(if_zs.product), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(8'd13, 8'd11, 16'h008F, 9, "m13x11");
    run_op(8'hFF, 8'hFF, 16'hFE01, 9, "mffxff");

    // Zero operand: skipping instance finishes at once, the other iterates to the same zero
    if_zs.a = 8'h00;
    if_zs.b = 8'h5A;
    if_zs.start = 1'b1;
    tick();
    if_zs.start = 1'b0;
    lat = 1;
    lat_zs = 0;
    lat_nz = 0;
    p_zs = 16'hFFFF;
    p_nz = 16'hFFFF;
    forever begin
      if (if_zs.done && lat_zs == 0) begin lat_zs = lat; p_zs = if_zs.product; end
      if (if_nz.done && lat_nz == 0) begin lat_nz = lat; p_nz = if_nz.product; end
      if ((lat_zs != 0 && lat_nz != 0) || lat >= 30) break;
      tick();
      lat++;
    end
    chk("zskip_lat", 32'(lat_zs), 32'd1);
    chk("zskip_prod", 32'(p_zs), 32'd0);
    chk("noskip_lat", 32'(lat_nz), 32'd9);
    chk("noskip_prod", 32'(p_nz), 32'd0);
    last_p = 16'h0000;
    repeat (2) tick();

    // Starts during CALC and during DONE must be dropped
    if_zs.a = 8'h12;
    if_zs.b = 8'h34;
    if_zs.start = 1'b1;
    tick();
    if_zs.start = 1'b0;
    lat = 1;
    repeat (2) begin tick(); lat++; end
    if_zs.a = 8'h55;
    if_zs.b = 8'h66;
    if_zs.start = 1'b1;
    tick();
    lat++;
    if_zs.start = 1'b0;
    while (!if_zs.done && lat < 30) begin tick(); lat++; end
    chk("ign_lat", 32'(lat), 32'd9);
    chk("ign_prod", 32'(if_zs.product), 32'h03A8);
    if_zs.a = 8'h77;
    if_zs.b = 8'h88;
    if_zs.start = 1'b1;
    tick();
    if_zs.start = 1'b0;
    chk("ign_done_start", 32'(if_zs.busy), 32'd0);
    repeat (3) tick();
    chk("ign_no_queue", 32'(if_zs.busy), 32'd0);
    chk("ign_prod_held", 32'(if_zs.product), 32'h03A8);
    last_p = 16'h03A8;
    run_op(8'h56, 8'h02, 16'h00AC, 9, "m56x02");

    // Asynchronous reset in the middle of an operation
    if_zs.a = 8'hA5;
    if_zs.b = 8'h3C;
    if_zs.start = 1'b1;
    tick();
    if_zs.start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(if_zs.busy), 32'd0);
    chk("arst_done", 32'(if_zs.done), 32'd0);
    chk("arst_prod", 32'(if_zs.product), 32'd0);
    repeat (3) tick();
    chk("arst_no_done", 32'(if_zs.done), 32'd0);
    rst_n = 1'b1;
    tick();
    last_p = 16'h0000;
    run_op(8'h02, 8'h03, 16'h0006, 9, "m02x03");

    // Start held high: corner pairs then random pairs, checked against a plain multiply
    pa.push_back(8'h01); pb.push_back(8'hFF);
    pa.push_back(8'h80); pb.push_back(8'h80);
    for (int i = 0; i < 256; i++) begin
      pa.push_back(8'($urandom_range(0, 255)));
      pb.push_back(8'($urandom_range(0, 255)));
    end
    idx = 0;
    edges = 0;
    if_zs.a = pa[0];
    if_zs.b = pb[0];
    if_zs.start = 1'b1;
    while (idx < pa.size()) begin
      tick();
      edges++;
      if (if_zs.done) begin
        exp_p = 16'(pa[idx]) * 16'(pb[idx]);
        exp_iv = ((idx == 0) ? 0 : 1) + (((pa[idx] == 8'h00) || (pb[idx] == 8'h00)) ? 1 : 9);
        chk("b2b_prod", 32'(if_zs.product), 32'(exp_p));
        chk("b2b_gap", 32'(edges), 32'(exp_iv));
        last_p = exp_p;
        idx++;
        edges = 0;
        if (idx < pa.size()) begin
          if_zs.a = pa[idx];
          if_zs.b = pb[idx];
        end
      end else begin
        chk("b2b_hold", 32'(if_zs.product), 32'(last_p));
        if (edges >= 30) begin
          chk("b2b_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
    if_zs.start = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
